// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : Single-bit full adder cell shared by the serial sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum and carry of three input bits
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule

// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial add/subtract sequencer. One full_adder is reused
//               over WIDTH cycles, LSB first, with a start/busy/done
//               handshake, held result, carry-out and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    // A 1-bit counter is still needed when WIDTH==1 ($clog2(1)==0)
    localparam int             CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_c_out;
    logic               r_overflow;
    logic [WIDTH-1:0]   w_sum_next;
    logic               w_fa_s;
    logic               w_fa_co;
    logic               w_accept;
    logic               w_last;

    full_adder u_fa (
        .a  (r_a_sr[0]),
        .b  (r_b_sr[0]),
        .ci (r_carry),
        .s  (w_fa_s),
        .co (w_fa_co)
    );

    // A new operation may only start from IDLE or the single DONE cycle
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_cnt == C_LAST);

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB
    generate
        if (WIDTH == 1) begin : g_sum_one
            assign w_sum_next = w_fa_s;
        end else begin : g_sum_wide
            assign w_sum_next = {w_fa_s, r_sum[WIDTH-1:1]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand load on accept, then one bit per cycle through the shared adder
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_sr     <= '0;
            r_b_sr     <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_c_out    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_a_sr  <= a;
            r_b_sr  <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : c_in;
            r_cnt   <= '0;
            r_sum   <= '0;
        end else if (r_state == S_RUN) begin
            r_sum   <= w_sum_next;
            r_a_sr  <= r_a_sr >> 1;
            r_b_sr  <= r_b_sr >> 1;
            r_carry <= w_fa_co;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                // Overflow: carry into the MSB differs from carry out of it
                r_c_out    <= w_fa_co;
                r_overflow <= w_fa_co ^ r_carry;
            end
        end
    end

    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign sum      = r_sum;
    assign c_out    = r_c_out;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench for serial_add_ctrl at WIDTH=8 and
//               WIDTH=1 against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       reset;

    logic       start8, sub8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    logic       start1, sub1, cin1;
    logic [0:0] a1, b1;
    logic       busy1, done1, cout1, ovf1;
    logic [0:0] sum1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .c_in(cin8), .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8),
        .overflow(ovf8)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .c_in(cin1), .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1),
        .overflow(ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {c_out, overflow, sum} from plain modular arithmetic
    function automatic logic [9:0] model(input int w, input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic sub);
        logic [7:0] mask, bb, s, am;
        logic [8:0] full;
        logic       ci, co, ov;
        int         msb;
        msb  = w - 1;
        mask = (w == 8) ? 8'hFF : 8'h01;
        am   = a & mask;
        bb   = (sub ? ~b : b) & mask;
        ci   = sub ? 1'b1 : cin;
        full = {1'b0, am} + {1'b0, bb} + {8'd0, ci};
        s    = full[7:0] & mask;
        co   = full[w];
        ov   = (am[msb] == bb[msb]) && (s[msb] != am[msb]);
        return {co, ov, s};
    endfunction

    // One operation on the selected DUT; optional stray start at cycle `glitch`
    task automatic do_op(input bit w1, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub, input int glitch);
        logic [9:0] e;
        int         w, cyc, bcnt, extra;
        logic [7:0] held;
        w = w1 ? 1 : 8;
        e = model(w, a, b, cin, sub);
        if (w1) begin
            a1 = a[0:0]; b1 = b[0:0]; cin1 = cin; sub1 = sub; start1 = 1'b1;
        end else begin
            a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
        end
        @(posedge clk); #1;
        start1 = 1'b0; start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
        a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom); sub1 = 1'($urandom);
        chk("sum_cleared", w1 ? {7'd0, sum1} : sum8, 0);
        cyc = 1; bcnt = 0;
        while (!(w1 ? done1 : done8) && cyc < 40) begin
            if (w1 ? busy1 : busy8) bcnt++;
            if (cyc == glitch) begin
                if (w1) start1 = 1'b1; else start8 = 1'b1;
            end
            @(posedge clk); #1;
            start1 = 1'b0; start8 = 1'b0;
            cyc++;
        end
        chk("latency", cyc, w + 1);
        chk("busy_cycles", bcnt, w);
        chk("busy_at_done", w1 ? busy1 : busy8, 0);
        chk("sum", w1 ? {7'd0, sum1} : sum8, {24'd0, e[7:0]});
        chk("c_out", w1 ? cout1 : cout8, e[9]);
        chk("overflow", w1 ? ovf1 : ovf8, e[8]);
        held = w1 ? {7'd0, sum1} : sum8;
        extra = 0;
        for (int i = 0; i < w + 2; i++) begin
            @(posedge clk); #1;
            if (w1 ? done1 : done8) extra++;
        end
        chk("single_done", extra, 0);
        chk("sum_held", w1 ? {7'd0, sum1} : sum8, held);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [9:0] e;
        start8 = 0; sub8 = 0; cin8 = 0; a8 = 0; b8 = 0;
        start1 = 0; sub1 = 0; cin1 = 0; a1 = 0; b1 = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum", sum8, 0);
        chk("rst_cout", cout8, 0);
        chk("rst_ovf", ovf8, 0);
        chk("rst_w1", {busy1, done1, sum1, cout1, ovf1}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases at WIDTH=8
        do_op(0, 8'h3C, 8'h0F, 1'b0, 1'b0, -1);
        do_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, -1);
        do_op(0, 8'h7F, 8'h00, 1'b1, 1'b0, -1);
        do_op(0, 8'h05, 8'h07, 1'b1, 1'b1, -1);
        do_op(0, 8'h12, 8'h34, 1'b0, 1'b0, 3);
        do_op(0, 8'h80, 8'h01, 1'b0, 1'b1, -1);

        // Start held across two operations: no IDLE between them
        a8 = 8'h01; b8 = 8'h01; cin8 = 0; sub8 = 0; start8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'h10; b8 = 8'h20;
        cyc = 1;
        while (!done8 && cyc < 40) begin @(posedge clk); #1; cyc++; end
        chk("b2b_lat1", cyc, 9);
        chk("b2b_sum1", sum8, 8'h02);
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("b2b_no_idle", busy8, 1);
        cyc = 1;
        while (!done8 && cyc < 40) begin @(posedge clk); #1; cyc++; end
        chk("b2b_gap", cyc, 9);
        chk("b2b_sum2", sum8, 8'h30);
        @(posedge clk); #1;

        // Asynchronous reset mid-RUN, after a result with c_out=1/overflow=1
        do_op(0, 8'h80, 8'h01, 1'b0, 1'b1, -1);
        a8 = 8'h55; b8 = 8'h66; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_busy", busy8, 0);
        chk("arst_done", done8, 0);
        chk("arst_sum", sum8, 0);
        chk("arst_cout", cout8, 0);
        chk("arst_ovf", ovf8, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8) cyc++;
        end
        chk("arst_no_done", cyc, 0);
        do_op(0, 8'h3C, 8'h0F, 1'b0, 1'b0, -1);

        // WIDTH=1 cases
        do_op(1, 8'h01, 8'h01, 1'b1, 1'b0, -1);
        do_op(1, 8'h01, 8'h00, 1'b0, 1'b0, -1);
        do_op(1, 8'h00, 8'h00, 1'b1, 1'b0, -1);
        do_op(1, 8'h00, 8'h01, 1'b0, 1'b1, -1);

        // Randomized operations on both widths
        for (int i = 0; i < 20; i++) begin
            do_op(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), -1);
            do_op(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), -1);
        end

        e = model(8, 8'h00, 8'h00, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
